// File: rtl/radio_frame_serializer.sv
// radio_frame_serializer
// Packs N_CH channels of 2-bit I/Q into one word and shifts it out on a single
// serial line, with a one-cycle sync pulse on the first bit of every frame.
// A one-word hold buffer lets a new word queue while the current one shifts,
// so back-to-back frames leave no gap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no frame on the line; data_out/sync held low, waits for hold
// S_SHIFT | one bit per clock; reloads from hold on the last bit if ready
module radio_frame_serializer #(
  parameter int N_CH      = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [4*N_CH-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic [1:0]          mode,
  input  logic                clr_flags,
  output logic                data_out,
  output logic                sync,
  output logic                busy,
  output logic                overflow,
  output logic                underrun
);

  localparam int WORD_W = 4 * N_CH;
  localparam int CNT_W  = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   hold_word;
  logic                hold_valid;
  logic [WORD_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   test_cnt;
  logic [WORD_W-1:0]   cap_word;
  logic                last_bit;
  logic                load_shift;
  logic                capture;
  logic                drop;
  logic                underrun_set;

  // Word to capture this cycle, selected by the mode present on the strobe
  always_comb begin
    cap_word = sample_in;
    case (mode)
      2'd0: cap_word = sample_in;
      2'd1: cap_word = test_cnt;
      2'd2: cap_word = {(WORD_W/2){2'b10}};
      2'd3: cap_word = '1;
      default: cap_word = sample_in;
    endcase
  end

  assign last_bit     = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
  // The shifter empties the hold buffer either from idle or on the last bit
  // of the current frame; a strobe on that same edge can refill it.
  assign load_shift   = hold_valid && ((state == S_IDLE) || last_bit);
  assign capture      = sample_valid && (!hold_valid || load_shift);
  assign drop         = sample_valid && !capture;
  assign underrun_set = last_bit && !hold_valid;

  // Hold buffer and test-pattern counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      test_cnt   <= '0;
    end else begin
      if (capture) begin
        hold_word  <= cap_word;
        hold_valid <= 1'b1;
        if (mode == 2'd1) test_cnt <= test_cnt + 1'b1;
      end else if (load_shift) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Serializer FSM with registered data_out, sync and busy
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_out  <= 1'b0;
      sync      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          data_out <= 1'b0;
          sync     <= 1'b0;
          if (hold_valid) begin
            shift_reg <= hold_word;
            bit_cnt   <= '0;
            state     <= S_SHIFT;
            busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          data_out  <= LSB_FIRST ? shift_reg[0] : shift_reg[WORD_W-1];
          sync      <= (bit_cnt == '0);
          shift_reg <= LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
          bit_cnt   <= bit_cnt + 1'b1;
          if (last_bit) begin
            if (hold_valid) begin
              shift_reg <= hold_word;
              bit_cnt   <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags; a set event on the same edge as clr_flags keeps the flag high
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (underrun_set)   underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radio_frame_serializer.sv
// Directed bench for radio_frame_serializer: three instances cover the
// 8-bit LSB-first, 8-bit MSB-first and 16-bit LSB-first configurations.
module tb_radio_frame_serializer;

  logic        sys_clk;
  logic        rst_n;
  logic [2:0]  sv;
  logic [15:0] sin  [3];
  logic [1:0]  mode [3];
  logic [2:0]  clr;
  logic [2:0]  dout, syn, busy, ovf, und;

  int n_cmp;
  int n_err;

  logic [15:0] stim_word [$];
  logic [1:0]  stim_mode [$];
  logic [15:0] exp_word  [$];

  radio_frame_serializer #(.N_CH(2), .LSB_FIRST(1'b1)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_in(sin[0][7:0]),
    .sample_valid(sv[0]), .mode(mode[0]), .clr_flags(clr[0]),
    .data_out(dout[0]), .sync(syn[0]), .busy(busy[0]),
    .overflow(ovf[0]), .underrun(und[0]));

  radio_frame_serializer #(.N_CH(2), .LSB_FIRST(1'b0)) dut_msb (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_in(sin[1][7:0]),
    .sample_valid(sv[1]), .mode(mode[1]), .clr_flags(clr[1]),
    .data_out(dout[1]), .sync(syn[1]), .busy(busy[1]),
    .overflow(ovf[1]), .underrun(und[1]));

  radio_frame_serializer #(.N_CH(4), .LSB_FIRST(1'b1)) dut_w16 (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_in(sin[2]),
    .sample_valid(sv[2]), .mode(mode[2]), .clr_flags(clr[2]),
    .data_out(dout[2]), .sync(syn[2]), .busy(busy[2]),
    .overflow(ovf[2]), .underrun(und[2]));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Strobes stim_word/stim_mode every 'period' cycles starting at edge 0 and
  // deserializes the line from edge 2 on, expecting exp_word back to back.
  task automatic run_frames(input int sel, input int width, input bit lsb,
                            input int period, input int nstrobe,
                            input int ncycles, input int clr_at);
    int          fi;
    int          i;
    int          bad_sync;
    int          und_mid;
    logic [15:0] w;
    fi = 0; bad_sync = 0; und_mid = 0; w = '0;
    for (int t = 0; t < ncycles; t++) begin
      if ((t % period == 0) && (t / period < nstrobe)) begin
        sv[sel]   = 1'b1;
        sin[sel]  = stim_word[t / period];
        mode[sel] = stim_mode[t / period];
      end else begin
        sv[sel]   = 1'b0;
        sin[sel]  = 16'(16'hDEAD ^ t);
        mode[sel] = 2'(t);
      end
      clr[sel] = (t == clr_at);
      tick();
      if (t == clr_at) chk("ovf set wins over clr", 32'(ovf[sel]), 32'd1);
      if (t >= 2 && fi < exp_word.size()) begin
        i = (t - 2) % width;
        if (syn[sel] != (i == 0)) bad_sync++;
        if (fi + 1 < exp_word.size() && und[sel]) und_mid++;
        if (lsb) w[i] = dout[sel];
        else     w[width-1-i] = dout[sel];
        if (i == width - 1) begin
          chk($sformatf("sel%0d frame%0d", sel, fi), 32'(w), 32'(exp_word[fi]));
          fi++;
          w = '0;
        end
      end
    end
    sv[sel]  = 1'b0;
    clr[sel] = 1'b0;
    chk($sformatf("sel%0d sync pattern errors", sel), bad_sync, 0);
    chk($sformatf("sel%0d underrun mid-stream", sel), und_mid, 0);
    chk($sformatf("sel%0d frames seen", sel), fi, exp_word.size());
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    sv = '0; clr = '0;
    for (int k = 0; k < 3; k++) begin
      sin[k]  = '0;
      mode[k] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset sync", 32'(syn), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset flags", 32'({ovf, und}), 32'd0);
    @(negedge sys_clk) rst_n = 1'b1;
    tick();

    // Single MODE0 frame 0xB4, LSB first: 0,0,1,0,1,1,0,1 then underrun
    stim_word = '{16'h00B4};
    stim_mode = '{2'd0};
    exp_word  = '{16'h00B4};
    run_frames(0, 8, 1'b1, 8, 1, 10, -1);
    chk("single frame underrun", 32'(und[0]), 32'd1);
    chk("single frame busy low", 32'(busy[0]), 32'd0);
    tick();
    chk("idle dout low", 32'(dout[0]), 32'd0);
    chk("idle sync low", 32'(syn[0]), 32'd0);

    // Async reset in the middle of an all-ones frame
    sv[0] = 1'b1; mode[0] = 2'd3;
    tick();
    sv[0] = 1'b0; mode[0] = 2'd0;
    tick(); tick(); tick();
    chk("mid-frame busy", 32'(busy[0]), 32'd1);
    chk("mid-frame dout", 32'(dout[0]), 32'd1);
    #2 rst_n = 1'b0;
    #2;
    chk("async reset dout", 32'(dout[0]), 32'd0);
    chk("async reset busy", 32'(busy[0]), 32'd0);
    chk("async reset flags", 32'({ovf[0], und[0]}), 32'd0);
    tick(); tick();
    @(negedge sys_clk) rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (syn[0] || dout[0] || busy[0]) seen++;
      end
      chk("no frame after reset release", seen, 0);
    end

    // Strobes every 2 cycles: A and B sent intact, C and D dropped
    stim_word = '{16'h005A, 16'h003C, 16'h00C3, 16'h0099};
    stim_mode = '{2'd0, 2'd0, 2'd0, 2'd0};
    exp_word  = '{16'h005A, 16'h003C};
    run_frames(0, 8, 1'b1, 2, 4, 18, 4);
    chk("overflow sticky", 32'(ovf[0]), 32'd1);
    chk("underrun after burst", 32'(und[0]), 32'd1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("overflow cleared", 32'(ovf[0]), 32'd0);
    chk("underrun cleared", 32'(und[0]), 32'd0);

    // Counter mode, gapless frames every 8 cycles through the 0xFF wrap
    stim_word.delete(); stim_mode.delete(); exp_word.delete();
    for (int k = 0; k < 260; k++) begin
      stim_word.push_back(16'h0055);
      stim_mode.push_back(2'd1);
      exp_word.push_back(16'(k & 8'hFF));
    end
    run_frames(0, 8, 1'b1, 8, 260, 8 * 260 + 2, -1);
    chk("counter overflow flag", 32'(ovf[0]), 32'd0);

    // MSB first: alternating pattern then 0xB4 (1,0,1,1,0,1,0,0)
    stim_word = '{16'h0000, 16'h00B4};
    stim_mode = '{2'd2, 2'd0};
    exp_word  = '{16'h00AA, 16'h00B4};
    run_frames(1, 8, 1'b0, 8, 2, 18, -1);
    chk("msb overflow flag", 32'(ovf[1]), 32'd0);

    // 16-bit word: all-ones frames every 16 cycles, then radio data
    stim_word = '{16'h0000, 16'h0000, 16'h0000, 16'h1234};
    stim_mode = '{2'd3, 2'd3, 2'd3, 2'd0};
    exp_word  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234};
    run_frames(2, 16, 1'b1, 16, 4, 66, -1);
    chk("w16 overflow flag", 32'(ovf[2]), 32'd0);
    chk("w16 underrun at end", 32'(und[2]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
